// File: rtl/tug_playfield.sv
// Tug-of-war playfield.
// Two players pull a single light along an NLED-wide LED bar. Each raw key is
// synchronized, edge-detected and turned into a one-cycle press. A left press
// moves the light toward bit NLED-1 and a right press moves it toward bit 0.
// A press that pushes the light past its end wins the round. The round then
// holds for HOLD_CYCLES cycles, and the light is re-centred for a new round.
//
// Ports
//   Clock  : sole clock, rising edge
//   Reset  : synchronous, active-high
//   L, R   : raw left/right keys, active-high, asynchronous to Clock
//   LEDR   : one-hot playfield lights (bit NLED-1 = left end, bit 0 = right end)
//   win_l  : registered one-cycle pulse, left player won
//   win_r  : registered one-cycle pulse, right player won
//   over   : high while the round is over (holding before re-centre)
module tug_playfield #(
  parameter int unsigned NLED        = 9,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            L,
  input  logic            R,
  output logic [NLED-1:0] LEDR,
  output logic            win_l,
  output logic            win_r,
  output logic            over
);

  localparam int unsigned CntW   = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned Center = (NLED - 1) / 2;

  localparam logic [NLED-1:0] LedOne    = {{(NLED-1){1'b0}}, 1'b1};
  localparam logic [NLED-1:0] CenterLed = LedOne << Center;
  localparam logic [CntW-1:0] CntLast   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  typedef enum logic {StPlay, StOver} state_e;

  // Key conditioning: two synchronizer flops, then a previous-value flop.
  // Reset loads ones so a key held across reset does not look like a press.
  logic l_meta, l_sync, l_prev;
  logic r_meta, r_sync, r_prev;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      l_meta <= 1'b1;
      l_sync <= 1'b1;
      l_prev <= 1'b1;
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      l_meta <= L;
      l_sync <= l_meta;
      l_prev <= l_sync;
      r_meta <= R;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  logic press_l, press_r, move_l, move_r;

  always_comb begin
    press_l = l_sync & ~l_prev;
    press_r = r_sync & ~r_prev;
    // Simultaneous presses cancel each other.
    move_l  = press_l & ~press_r;
    move_r  = press_r & ~press_l;
  end

  // Round state
  state_e            state_q, state_d;
  logic [NLED-1:0]   led_q, led_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              win_l_q, win_l_d;
  logic              win_r_q, win_r_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StPlay;
      led_q   <= CenterLed;
      cnt_q   <= '0;
      win_l_q <= 1'b0;
      win_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      cnt_q   <= cnt_d;
      win_l_q <= win_l_d;
      win_r_q <= win_r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    cnt_d   = cnt_q;
    win_l_d = 1'b0;
    win_r_d = 1'b0;
    unique case (state_q)
      StPlay: begin
        if (move_l) begin
          // Pushing past the left end wins; the light stays at the end.
          if (led_q[NLED-1]) begin
            state_d = StOver;
            win_l_d = 1'b1;
            cnt_d   = '0;
          end else begin
            led_d = led_q << 1;
          end
        end else if (move_r) begin
          if (led_q[0]) begin
            state_d = StOver;
            win_r_d = 1'b1;
            cnt_d   = '0;
          end else begin
            led_d = led_q >> 1;
          end
        end
      end
      StOver: begin
        // The win edge itself is the first OVER cycle, so leaving when the
        // counter reaches HOLD_CYCLES-1 gives exactly HOLD_CYCLES cycles.
        if (cnt_q == CntLast) begin
          state_d = StPlay;
          led_d   = CenterLed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
    endcase
  end

  always_comb begin
    LEDR  = led_q;
    win_l = win_l_q;
    win_r = win_r_q;
    over  = (state_q == StOver);
  end

endmodule

// File: tb/tb_tug_playfield.sv
// Bench for tug_playfield (NLED=9, HOLD_CYCLES=4).
// Each stimulus step waits for a rising edge, drives the keys/reset and pushes
// the hand-computed outputs expected right after that edge. A monitor pops
// one expectation at every falling edge and compares it with the DUT.
module tb_tug_playfield;

  logic       clk;
  logic       rst;
  logic       l;
  logic       r;
  logic [8:0] ledr;
  logic       win_l;
  logic       win_r;
  logic       over;

  typedef struct packed {
    logic [8:0] led;
    logic       wl;
    logic       wr;
    logic       ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_step = 0;

  tug_playfield #(
    .NLED       (9),
    .HOLD_CYCLES(4)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .L    (l),
    .R    (r),
    .LEDR (ledr),
    .win_l(win_l),
    .win_r(win_r),
    .over (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare whatever the DUT shows against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      if (ledr !== e.led || win_l !== e.wl || win_r !== e.wr || over !== e.ov) begin
        n_bad++;
        $display("FAIL step %0d: got led=%b wl=%b wr=%b over=%b, want led=%b wl=%b wr=%b over=%b",
                 n_step, ledr, win_l, win_r, over, e.led, e.wl, e.wr, e.ov);
      end
      n_step++;
    end
  end

  // One clock: wait for the edge, drive inputs, expect outputs after that edge.
  task automatic step(input logic rst_v, input logic l_v, input logic r_v, input int idx,
                      input logic wl, input logic wr, input logic ov);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rst_v;
    l   = l_v;
    r   = r_v;
    e.led = 9'd1 << idx;
    e.wl  = wl;
    e.wr  = wr;
    e.ov  = ov;
    sb_q.push_back(e);
  endtask

  // One-cycle key pulse; the light moves three edges after it is driven.
  task automatic key_pulse(input logic l_v, input logic r_v, input int pre, input int post);
    step(1'b0, l_v, r_v, pre, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, pre, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, pre, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, post, 1'b0, 1'b0, 1'b0);
  endtask

  // Left key held for 10 cycles: exactly one move.
  task automatic key_hold(input int pre, input int post);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, (i < 3) ? pre : post, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, post, 1'b0, 1'b0, 1'b0);
  endtask

  // Winning press from an end bit, optional L then R pokes during OVER,
  // four OVER cycles and re-centre.
  task automatic key_win(input logic l_v, input logic r_v, input int idx, input logic poke);
    step(1'b0, l_v, r_v, idx, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, idx, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, idx, 1'b0, 1'b0, 1'b0);
    step(1'b0, poke, 1'b0, idx, l_v, r_v, 1'b1);
    step(1'b0, 1'b0, poke, idx, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, idx, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, idx, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    l   = 1'b0;
    r   = 1'b0;

    // Reset state, then let the synchronizers drain their reset ones.
    step(1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);

    key_pulse(1'b1, 1'b0, 4, 5);   // single left move
    key_hold(5, 6);                // held key, one move
    key_pulse(1'b1, 1'b1, 6, 6);   // simultaneous presses cancel
    key_pulse(1'b0, 1'b1, 6, 5);   // right move
    key_pulse(1'b1, 1'b0, 5, 6);
    key_pulse(1'b1, 1'b0, 6, 7);
    key_pulse(1'b1, 1'b0, 7, 8);
    key_pulse(1'b1, 1'b1, 8, 8);   // cancel at the left end: no win
    key_pulse(1'b0, 1'b1, 8, 7);   // opposing press at end moves inward
    key_pulse(1'b1, 1'b0, 7, 8);
    key_win(1'b1, 1'b0, 8, 1'b0);  // left win, back to centre

    // Five left presses from centre.
    for (int i = 4; i < 8; i++) key_pulse(1'b1, 1'b0, i, i + 1);
    key_win(1'b1, 1'b0, 8, 1'b0);

    // Right side, inward move at bit 0, then a win with pokes during OVER.
    for (int i = 4; i > 0; i--) key_pulse(1'b0, 1'b1, i, i - 1);
    key_pulse(1'b1, 1'b0, 0, 1);
    key_pulse(1'b0, 1'b1, 1, 0);
    key_win(1'b0, 1'b1, 0, 1'b1);

    // Reset in the middle of OVER with L held through and after reset.
    for (int i = 4; i < 8; i++) key_pulse(1'b1, 1'b0, i, i + 1);
    step(1'b0, 1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0);
    key_pulse(1'b0, 1'b1, 4, 3);   // play resumes normally

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
